// File: rtl/ibus_responder.sv
// ibus_responder: single-outstanding instruction-bus responder in front of a grant/rvalid memory backend.
// Optional last-word buffer enabled by defining IBUS_RESP_BYPASS_EN.
`default_nettype none

package ibus_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
endpackage

module ibus_responder
    import ibus_pkg::*;
#(
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  ibus_req_t   ireq,
    output ibus_resp_t  iresp,
    output logic        fetch_err,
    input  logic        inv,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr_q;
    logic [31:0] r_data_q;
    logic        r_err_q;
    logic        w_aligned;
    logic        w_hit;
    logic        w_fill;

    assign w_aligned = (ireq.addr[1:0] == 2'b00);
    assign w_fill    = (r_state == S_WAIT) && mem_rvalid;

`ifdef IBUS_RESP_BYPASS_EN
    logic        r_buf_valid;
    logic [29:0] r_buf_addr;
    logic [31:0] r_buf_data;

    // A same-cycle invalidate forces a miss so stale code is never returned.
    assign w_hit = r_buf_valid && !inv && w_aligned && (ireq.addr[31:2] == r_buf_addr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
        end else if (w_fill) begin
            r_buf_valid <= !inv;
            r_buf_addr  <= r_addr_q[31:2];
            r_buf_data  <= mem_rdata;
        end else if (inv) begin
            r_buf_valid <= 1'b0;
        end
    end

    logic [1:0] w_unused_addr_lsb;
    assign w_unused_addr_lsb = r_addr_q[1:0];
`else
    assign w_hit = 1'b0;

    logic [2:0] w_unused_bits;
    assign w_unused_bits = {inv, r_addr_q[1:0]};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        iresp         = '0;
        iresp.data    = r_data_q;
        fetch_err     = 1'b0;
        mem_req       = 1'b0;
        mem_addr      = '0;
        case (r_state)
            S_IDLE: begin
                // Gate with reset so nothing is acknowledged while held in reset.
                iresp.addr_ok = ireq.valid && resetn;
                if (ireq.valid) begin
                    w_state_nxt = (!w_aligned || w_hit) ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {r_addr_q[31:2], 2'b00};
                if (mem_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                iresp.data_ok = 1'b1;
                fetch_err     = r_err_q;
                w_state_nxt   = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr_q <= '0;
            r_data_q <= '0;
            r_err_q  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && ireq.valid) begin
                r_addr_q <= ireq.addr;
                if (!w_aligned) begin
                    r_data_q <= ERR_DATA;
                    r_err_q  <= 1'b1;
                end else if (w_hit) begin
`ifdef IBUS_RESP_BYPASS_EN
                    r_data_q <= r_buf_data;
`endif
                    r_err_q  <= 1'b0;
                end
            end
            if (w_fill) begin
                r_data_q <= mem_rdata;
                r_err_q  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/ibus_responder.md
# ibus_responder

Instruction-bus responder that sits on the far side of the fetch stage's `ibus_req_t`/`ibus_resp_t` interface. It accepts one fetch request at a time, issues a single-word read to a grant/response-style instruction memory backend, and returns the word with a one-cycle `data_ok` pulse. Misaligned fetch addresses are answered locally with an error flag. An optional last-word buffer can answer repeated fetches without touching the backend.

## Interface
Parameters:
- `ERR_DATA`, default `32'h0000_0000`: data returned on a misaligned fetch.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ireq`  in  `ibus_req_t`  fetch request; uses `valid` and `addr[31:0]`.
- `iresp`  out  `ibus_resp_t`  response; uses `addr_ok`, `data_ok` and `data[31:0]`.
- `fetch_err`  out  1  pulses together with `data_ok` when the accepted address had `addr[1:0] != 0`.
- `inv`  in  1  invalidates the last-word buffer. Ignored when the buffer is compiled out.
- `mem_req`  out  1  backend read request; held until granted.
- `mem_addr`  out  32  backend word address; equals the captured address with `[1:0]` forced to 0.
- `mem_gnt`  in  1  backend accepts the request in this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read data.

## Operation
States: IDLE, REQ, WAIT, RESP. Reset state is IDLE.

Registers:
- `addr_q` (32): captured request address.
- `data_q` (32): response data.
- `err_q` (1): misaligned-fetch flag.

State behaviour:
- **IDLE**
  - `addr_ok = ireq.valid`, combinational. This is the only state in which `addr_ok` can be 1.
  - When `ireq.valid` is 1: capture `addr_q <= ireq.addr`.
  - If `ireq.addr[1:0] != 0`: set `data_q <= ERR_DATA`, `err_q <= 1`, go to RESP.
  - Otherwise: go to REQ.
- **REQ**
  - `mem_req = 1`, `mem_addr = {addr_q[31:2], 2'b00}`.
  - On `mem_gnt`: go to WAIT. Otherwise stay in REQ.
- **WAIT**
  - On `mem_rvalid`: `data_q <= mem_rdata`, `err_q <= 0`, go to RESP.
  - `mem_rvalid` is sampled only in WAIT; it is ignored in every other state.
- **RESP**
  - `iresp.data_ok = 1`, `iresp.data = data_q`, `fetch_err = err_q`.
  - Go to IDLE.

Request rules:
- Only one request is outstanding at a time.
- The request is fixed at the `addr_ok` cycle. Later changes to `ireq.addr`, or deassertion of `ireq.valid`, do not alter or cancel it.
- `data_ok` always fires exactly once per `addr_ok`.
- `iresp.data` is `data_q` in every state; it is only meaningful when `data_ok` is 1.

## Timing
Reset:
- While `resetn` is 0, state is IDLE immediately (asynchronous), regardless of the clock.
- Output values under reset: `addr_ok = 0`, `data_ok = 0`, `fetch_err = 0`, `mem_req = 0`, `mem_addr = 0`, `iresp.data = 0`.
- `addr_q`, `data_q` and `err_q` reset to 0.
- Reset asserted mid-transaction (REQ or WAIT) abandons the transaction with no `data_ok`. A later `mem_rvalid` from that read is ignored, because it arrives in IDLE.

Latency, with `addr_ok` in cycle 0:
- `mem_req` is first asserted in cycle 1.
- With grant in cycle 1 and `mem_rvalid` in cycle 2, `data_ok` is in cycle 3.
- Misaligned address: `data_ok` in cycle 1, with no backend access.
- After `data_ok`, the state is IDLE in the next cycle, so the earliest next `addr_ok` is cycle 4 (misaligned: cycle 2).

Backend stall:
- Grant and rvalid may each stall any number of cycles.
- `mem_req` and `mem_addr` stay stable until `mem_gnt`.

## Configuration
Macro: `IBUS_RESP_BYPASS_EN`.

Defined:
- A one-entry buffer holds `{buf_valid, buf_addr[31:2], buf_data}`.
- The buffer is filled on every backend completion, in the WAIT→RESP transition.
- In IDLE, a valid, aligned request with `ireq.addr[31:2] == buf_addr` and `buf_valid == 1` is a hit: `addr_ok = 1`, `data_q <= buf_data`, go straight to RESP. `data_ok` follows in cycle 1 with no `mem_req`.
- `inv` (sampled every cycle) and reset clear `buf_valid`.
- If `inv` is 1 in the same IDLE cycle as a request, the request misses.
- If `inv` is 1 during a fill cycle, `inv` wins: the buffer ends up invalid.

Undefined:
- No buffer exists and every aligned request goes to the backend.
- `inv` is ignored.

## Test plan
- Reset, then request `addr = 32'hbfc0_0000`, with `mem_gnt` in cycle 1 and `mem_rdata = 32'h2408_0001` with `mem_rvalid` in cycle 2 -> `addr_ok` in cycle 0, `mem_addr = 32'hbfc0_0000` in cycle 1, `data_ok` with `data = 32'h2408_0001` in cycle 3, `fetch_err = 0`.
- Backend stall: grant withheld 5 cycles, rvalid 3 cycles after grant -> `mem_req` and `mem_addr` held stable for 6 cycles, exactly one `data_ok`, and no `addr_ok` while busy even with `ireq.valid` held at 1.
- Request `addr = 32'hbfc0_0002` -> `data_ok` in cycle 1 with `data = ERR_DATA` and `fetch_err = 1`; `mem_req` never asserted.
- `ireq.addr` changed to `32'hbfc0_0100` in cycle 2 of an outstanding fetch to `32'hbfc0_0004` -> `mem_addr` stays `32'hbfc0_0004` and the response carries that word.
- Reset asserted in WAIT, then a stray `mem_rvalid` after reset -> no `data_ok`, state IDLE, all outputs 0.
- With `IBUS_RESP_BYPASS_EN`: two back-to-back fetches of `32'hbfc0_0008` -> the second gets `data_ok` 1 cycle after `addr_ok` with no `mem_req`. After pulsing `inv`, a third fetch of the same address goes to the backend.
